mem_issue_scheduler: RTL and testbench

- Schedules the single memory functional unit among the memory reservation-station entries. Tracks entries in allocation (program) order in an age queue.
- Each cycle, selects the oldest eligible entry under conservative load/store ordering and issues it when the memory FU is not busy.
- Sits between the memory reservation stations (allocation and operand-ready status) and the memory FU (execute_valid / packet mux select).

---
 rtl/mem_issue_scheduler.sv | 155 +++++++++++++++
 tb/tb_mem_issue_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_scheduler.sv
// mem_issue_scheduler
//   Arbitrates the single memory functional unit among the memory
//   reservation-station entries. Entries are kept in allocation order in an
//   age queue (slot 0 oldest). Each cycle the oldest eligible slot is issued
//   unless the FU is busy or a flush is in progress. Loads may bypass older
//   loads. Stores issue only from slot 0. A load never passes an older store.
//
// Ports:
//   clk_i            clock, all state on posedge
//   reset_i          synchronous active-low reset
//   alloc_valid_i    RS entry allocated this cycle
//   alloc_idx_i      index of the allocated RS entry
//   alloc_is_store_i allocated op is a store (1) or load (0)
//   entry_ready_i    per-RS-entry operands-available flags
//   fu_busy_i        memory FU busy, blocks issue
//   flush_i          pipeline flush, empties the queue
//   issue_valid_o    issue fires this cycle (combinational)
//   issue_idx_o      RS index being issued (0 when idle)
//   issue_is_store_o issued op is a store (0 when idle)
//   count_o          number of queued entries
//   full_o / empty_o occupancy flags from the registered count
//   alloc_err_o      one-cycle pulse: allocation dropped (overflow/duplicate)
module mem_issue_scheduler #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   alloc_valid_i,
  input  logic [IDX_W-1:0]       alloc_idx_i,
  input  logic                   alloc_is_store_i,
  input  logic [NUM_ENTRIES-1:0] entry_ready_i,
  input  logic                   fu_busy_i,
  input  logic                   flush_i,
  output logic                   issue_valid_o,
  output logic [IDX_W-1:0]       issue_idx_o,
  output logic                   issue_is_store_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   alloc_err_o
);

  logic [IDX_W-1:0] idx_q [NUM_ENTRIES];
  logic [IDX_W-1:0] idx_d [NUM_ENTRIES];
  logic             st_q  [NUM_ENTRIES];
  logic             st_d  [NUM_ENTRIES];
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             found;
  logic [IDX_W-1:0] sel_slot;
  logic             seen_store;
  logic             elig;
  logic             issue;
  logic             full;
  logic             dup;
  logic [CNT_W-1:0] wr_pos;

  assign full = (count_q == CNT_W'(NUM_ENTRIES));

  // Oldest-first selection; seen_store tracks whether any older valid slot
  // holds a store, which blocks every younger load.
  always_comb begin
    found      = 1'b0;
    sel_slot   = '0;
    seen_store = 1'b0;
    elig       = 1'b0;
    for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
      if (CNT_W'(k) < count_q) begin
        elig = entry_ready_i[idx_q[k]] && (st_q[k] ? (k == 0) : !seen_store);
        if (elig && !found) begin
          found    = 1'b1;
          sel_slot = IDX_W'(k);
        end
        if (st_q[k]) seen_store = 1'b1;
      end
    end
  end

  assign issue = found && !fu_busy_i && !flush_i;

  // Duplicate check excludes the slot retiring this cycle so its RS index
  // may be reallocated immediately.
  always_comb begin
    dup = 1'b0;
    for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
      if ((CNT_W'(k) < count_q) && (idx_q[k] == alloc_idx_i) &&
          !(issue && (IDX_W'(k) == sel_slot)))
        dup = 1'b1;
    end
  end

  assign wr_pos = count_q - CNT_W'(issue);

  always_comb begin
    idx_d   = idx_q;
    st_d    = st_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (flush_i) begin
      count_d = '0;
    end else begin
      // Remove the issued slot by shifting every younger slot down one.
      if (issue) begin
        for (int unsigned k = 0; k < NUM_ENTRIES - 1; k++) begin
          if (IDX_W'(k) >= sel_slot) begin
            idx_d[k] = idx_q[k+1];
            st_d[k]  = st_q[k+1];
          end
        end
        count_d = count_q - 1'b1;
      end
      if (alloc_valid_i) begin
        if (dup || (full && !issue)) begin
          err_d = 1'b1;
        end else begin
          for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
            if (CNT_W'(k) == wr_pos) begin
              idx_d[k] = alloc_idx_i;
              st_d[k]  = alloc_is_store_i;
            end
          end
          count_d = count_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Slot payload is don't-care outside 0..count-1, so it carries no reset.
  always_ff @(posedge clk_i) begin
    idx_q <= idx_d;
    st_q  <= st_d;
  end

  assign issue_valid_o    = issue;
  assign issue_idx_o      = issue ? idx_q[sel_slot] : '0;
  assign issue_is_store_o = issue ? st_q[sel_slot] : 1'b0;
  assign count_o          = count_q;
  assign full_o           = full;
  assign empty_o          = (count_q == '0);
  assign alloc_err_o      = err_q;

endmodule

// File: tb/tb_mem_issue_scheduler.sv
// Directed bench for mem_issue_scheduler (NUM_ENTRIES = 4).
module tb_mem_issue_scheduler;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       alloc_valid_i;
  logic [1:0] alloc_idx_i;
  logic       alloc_is_store_i;
  logic [3:0] entry_ready_i;
  logic       fu_busy_i;
  logic       flush_i;
  logic       issue_valid_o;
  logic [1:0] issue_idx_o;
  logic       issue_is_store_o;
  logic [2:0] count_o;
  logic       full_o;
  logic       empty_o;
  logic       alloc_err_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_issue_scheduler #(.NUM_ENTRIES(4)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_idx_i      (alloc_idx_i),
    .alloc_is_store_i (alloc_is_store_i),
    .entry_ready_i    (entry_ready_i),
    .fu_busy_i        (fu_busy_i),
    .flush_i          (flush_i),
    .issue_valid_o    (issue_valid_o),
    .issue_idx_o      (issue_idx_o),
    .issue_is_store_o (issue_is_store_o),
    .count_o          (count_o),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .alloc_err_o      (alloc_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs change away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [1:0] idx, input logic st);
    alloc_valid_i    = 1'b1;
    alloc_idx_i      = idx;
    alloc_is_store_i = st;
    tick();
    alloc_valid_i    = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; alloc_valid_i = 1'b0; alloc_idx_i = '0;
    alloc_is_store_i = 1'b0; entry_ready_i = '0; fu_busy_i = 1'b0;
    flush_i = 1'b0;

    // Reset
    tick(); tick();
    reset_i = 1'b1;
    #1;
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_issue", issue_valid_o, 0);
    check("rst_err", alloc_err_o, 0);

    // Load bypass: LW2 then LW0; younger ready load goes first
    alloc(2, 0);
    alloc(0, 0);
    entry_ready_i = 4'b0001; #1;
    check("byp_count", count_o, 2);
    check("byp_valid0", issue_valid_o, 1);
    check("byp_idx0", issue_idx_o, 0);
    check("byp_st0", issue_is_store_o, 0);
    tick();
    entry_ready_i = 4'b0100; #1;
    check("byp_valid2", issue_valid_o, 1);
    check("byp_idx2", issue_idx_o, 2);
    tick();
    entry_ready_i = 4'b0000; #1;
    check("byp_drained", count_o, 0);
    check("byp_empty", empty_o, 1);

    // Store ordering: SW1 then LW3
    alloc(1, 1);
    alloc(3, 0);
    entry_ready_i = 4'b1000; #1;
    check("ord_blocked", issue_valid_o, 0);
    entry_ready_i = 4'b1010; #1;
    check("ord_valid_st", issue_valid_o, 1);
    check("ord_idx_st", issue_idx_o, 1);
    check("ord_is_st", issue_is_store_o, 1);
    tick(); #1;
    check("ord_valid_ld", issue_valid_o, 1);
    check("ord_idx_ld", issue_idx_o, 3);
    check("ord_is_ld", issue_is_store_o, 0);
    tick();
    entry_ready_i = 4'b0000; #1;
    check("ord_drained", count_o, 0);

    // Busy stall
    alloc(0, 0);
    entry_ready_i = 4'b0001; fu_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_valid", issue_valid_o, 0);
      check("busy_count", count_o, 1);
      tick();
    end
    fu_busy_i = 1'b0; #1;
    check("busy_rel_valid", issue_valid_o, 1);
    check("busy_rel_idx", issue_idx_o, 0);
    tick();
    entry_ready_i = 4'b0000; #1;
    check("busy_drained", count_o, 0);

    // Duplicate index dropped
    alloc(1, 0);
    alloc(1, 0);
    #1;
    check("dup_err", alloc_err_o, 1);
    check("dup_count", count_o, 1);
    tick();
    check("dup_err_clr", alloc_err_o, 0);
    entry_ready_i = 4'b0010; tick();
    entry_ready_i = 4'b0000; #1;
    check("dup_drained", count_o, 0);

    // Full boundary
    for (int i = 0; i < 4; i++) alloc(2'(i), 1'b0);
    #1;
    check("full_count", count_o, 4);
    check("full_flag", full_o, 1);
    alloc(0, 0);
    #1;
    check("ovf_err", alloc_err_o, 1);
    check("ovf_count", count_o, 4);
    tick();
    check("ovf_err_clr", alloc_err_o, 0);
    entry_ready_i = 4'b0001;
    alloc_valid_i = 1'b1; alloc_idx_i = 2'd0; alloc_is_store_i = 1'b0;
    #1;
    check("swap_valid", issue_valid_o, 1);
    check("swap_idx", issue_idx_o, 0);
    tick();
    alloc_valid_i = 1'b0; entry_ready_i = 4'b0000; #1;
    check("swap_count", count_o, 4);
    check("swap_err", alloc_err_o, 0);
    // Queue is now {1,2,3,0}: idx3 (slot 2) beats idx0 (slot 3)
    entry_ready_i = 4'b1001; #1;
    check("tail_idx3", issue_idx_o, 3);
    entry_ready_i = 4'b0001; #1;
    check("tail_idx0", issue_idx_o, 0);
    entry_ready_i = 4'b1111;
    repeat (4) tick();
    entry_ready_i = 4'b0000; #1;
    check("full_drained", count_o, 0);

    // Flush with simultaneous alloc
    alloc(0, 0);
    alloc(1, 0);
    alloc(2, 1);
    entry_ready_i = 4'b1111; flush_i = 1'b1;
    alloc_valid_i = 1'b1; alloc_idx_i = 2'd3; alloc_is_store_i = 1'b0;
    #1;
    check("flush_noissue", issue_valid_o, 0);
    check("flush_pre_count", count_o, 3);
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0; #1;
    check("flush_count", count_o, 0);
    check("flush_empty", empty_o, 1);
    check("flush_err", alloc_err_o, 0);
    check("flush_idle", issue_valid_o, 0);

    // Reset mid-operation discards entries
    entry_ready_i = 4'b0000;
    alloc(2, 0);
    reset_i = 1'b0; entry_ready_i = 4'b0100;
    tick();
    reset_i = 1'b1; #1;
    check("midrst_count", count_o, 0);
    check("midrst_idle", issue_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
